// File: rtl/digpot_wiper_rx.sv
// Responder/monitor for an X9C-style INC / U-Dn / CSn digital pot interface.
// Filters the pot wires, tracks the wiper and exposes state over Wishbone.
module digpot_wiper_rx #(
    parameter int TAPS     = 100,
    parameter int INIT_TAP = 0,
    parameter int FILT     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        inc_i,
    input  logic        udn_i,
    input  logic        csn_i,
    output logic [6:0]  wiper_o,
    output logic        step_o
);

    localparam int          RW   = $clog2(FILT + 1);
    localparam logic [6:0]  TOP  = 7'(TAPS - 1);
    localparam logic [6:0]  INIT = 7'(INIT_TAP);
    localparam logic [RW-1:0] FN = RW'(FILT);
    // wire order: [2] csn, [1] udn, [0] inc
    localparam logic [2:0]  IDLE = 3'b101;

    logic [2:0]         s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [2:0]         filt_q, filt_d, vld_q, vld_d;
    logic [2:0][RW-1:0] run_q, run_d;

    logic [6:0]  wiper_q, wiper_d, nv_q, nv_d;
    logic [15:0] up_q, up_d, dn_q, dn_d;
    logic [7:0]  ign_q, ign_d;
    logic        sat_hi_q, sat_hi_d, sat_lo_q, sat_lo_d;
    logic        step_q, step_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;

    logic        inc_fall, csn_rise;
    logic        step_ev, ign_ev, store_ev;
    logic        req, wr;
    logic [1:0]  adr;
    logic [31:0] rdata;
    logic        unused_bits;

    assign unused_bits = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0],
                           wb_dat_i[31:9], wb_dat_i[7]};

    // A wire level is accepted after FILT equal samples; the first
    // acceptance after reset only arms the wire and never forms an edge.
    always_comb begin
        s1_d = {csn_i, udn_i, inc_i};
        s2_d = s1_q;
        s3_d = s2_q;
        for (int i = 0; i < 3; i++) begin
            if (s2_q[i] == s3_q[i]) begin
                run_d[i] = (run_q[i] == FN) ? run_q[i] : run_q[i] + RW'(1);
            end else begin
                run_d[i] = RW'(1);
            end
            filt_d[i] = (run_d[i] == FN) ? s2_q[i] : filt_q[i];
            vld_d[i]  = vld_q[i] | (run_d[i] == FN);
        end
    end

    assign inc_fall = vld_q[0] & filt_q[0] & ~filt_d[0];
    assign csn_rise = vld_q[2] & ~filt_q[2] & filt_d[2];
    assign step_ev  = inc_fall & ~filt_q[2];
    assign ign_ev   = inc_fall & filt_q[2];
    assign store_ev = csn_rise & filt_q[0];

    assign req = wb_stb_i & wb_cyc_i & ~ack_q;
    assign wr  = req & wb_we_i;
    assign adr = wb_adr_i[3:2];

    always_comb begin
        rdata = '0;
        unique case (adr)
            2'd0: rdata = {25'b0, wiper_q};
            2'd1: rdata = {25'b0, nv_q};
            2'd2: rdata = {dn_q, up_q};
            2'd3: rdata = {16'b0, ign_q, 3'b0, filt_q[1], filt_q[0],
                           filt_q[2], sat_lo_q, sat_hi_q};
        endcase
    end

    always_comb begin
        wiper_d  = wiper_q;
        nv_d     = nv_q;
        up_d     = up_q;
        dn_d     = dn_q;
        ign_d    = ign_q;
        sat_hi_d = sat_hi_q;
        sat_lo_d = sat_lo_q;
        step_d   = step_ev;
        ack_d    = req;
        dat_d    = req ? rdata : dat_q;

        // store samples the pre-step wiper
        if (store_ev) nv_d = wiper_q;

        if (step_ev) begin
            if (filt_q[1]) begin
                if (wiper_q >= TOP) sat_hi_d = 1'b1;
                else                wiper_d  = wiper_q + 7'd1;
                if (up_q != 16'hFFFF) up_d = up_q + 16'd1;
            end else begin
                if (wiper_q == 7'd0) sat_lo_d = 1'b1;
                else                 wiper_d  = wiper_q - 7'd1;
                if (dn_q != 16'hFFFF) dn_d = dn_q + 16'd1;
            end
        end

        if (ign_ev && ign_q != 8'hFF) ign_d = ign_q + 8'd1;

        // bus writes are applied last so they win over same-cycle events
        if (wr) begin
            unique case (adr)
                2'd0: wiper_d = (wb_dat_i[6:0] > TOP) ? TOP : wb_dat_i[6:0];
                2'd1: ;
                2'd2: begin
                    up_d = '0;
                    dn_d = '0;
                end
                2'd3: begin
                    if (wb_dat_i[0]) sat_hi_d = 1'b0;
                    if (wb_dat_i[1]) sat_lo_d = 1'b0;
                    if (wb_dat_i[8]) ign_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= IDLE;
            s2_q     <= IDLE;
            s3_q     <= IDLE;
            filt_q   <= IDLE;
            vld_q    <= '0;
            run_q    <= '0;
            wiper_q  <= INIT;
            nv_q     <= INIT;
            up_q     <= '0;
            dn_q     <= '0;
            ign_q    <= '0;
            sat_hi_q <= 1'b0;
            sat_lo_q <= 1'b0;
            step_q   <= 1'b0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            filt_q   <= filt_d;
            vld_q    <= vld_d;
            run_q    <= run_d;
            wiper_q  <= wiper_d;
            nv_q     <= nv_d;
            up_q     <= up_d;
            dn_q     <= dn_d;
            ign_q    <= ign_d;
            sat_hi_q <= sat_hi_d;
            sat_lo_q <= sat_lo_d;
            step_q   <= step_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
        end
    end

    assign wiper_o  = wiper_q;
    assign step_o   = step_q;
    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;

endmodule
